// File: rtl/bch_serial_syndrome_pkg.sv
// Field helpers for the bit-serial BCH syndrome generator: primitive polynomials,
// powers of alpha and constant GF(2^m) multiply matrices.
package bch_serial_syndrome_pkg;

  localparam int GF_MAX_M = 16;

  typedef logic [GF_MAX_M-1:0] gf_word_t;
  typedef gf_word_t [GF_MAX_M-1:0] gf_matrix_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD
  } state_t;

  function automatic logic [GF_MAX_M:0] bch_polynomial(input int m);
    case (m)
      2:       return 17'h00007;
      3:       return 17'h0000b;
      4:       return 17'h00013;
      5:       return 17'h00025;
      6:       return 17'h00043;
      7:       return 17'h00083;
      8:       return 17'h0011d;
      9:       return 17'h00211;
      10:      return 17'h00409;
      11:      return 17'h00805;
      12:      return 17'h01053;
      13:      return 17'h0201b;
      14:      return 17'h04443;
      15:      return 17'h08003;
      16:      return 17'h1100b;
      default: return 17'h00013;
    endcase
  endfunction

  function automatic gf_word_t alpha_pow(input int e, input int m);
    logic [GF_MAX_M:0] r;
    logic [GF_MAX_M:0] poly;
    poly = bch_polynomial(m);
    r = {{GF_MAX_M{1'b0}}, 1'b1};
    for (int i = 0; i < e; i++) begin
      r = r << 1;
      if (r[m]) r = r ^ poly;
    end
    return r[GF_MAX_M-1:0];
  endfunction

  // Column i is the image of basis element alpha^i, i.e. alpha^(mult*i + offset).
  // mult=1/offset=J gives "times alpha^J"; mult=2/offset=0 gives squaring.
  function automatic gf_matrix_t power_matrix(input int mult, input int offset, input int m);
    gf_matrix_t mat;
    mat = '0;
    for (int i = 0; i < m; i++) mat[i] = alpha_pow(mult * i + offset, m);
    return mat;
  endfunction

  function automatic int trailing_zeros(input int v);
    int n;
    int x;
    n = 0;
    x = v;
    while (x > 0 && (x % 2) == 0) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bch_serial_syndrome_acc.sv
// One odd-syndrome Horner accumulator: acc <= acc * alpha^J + bit, with a
// reload path for the first bit of a codeword.
module bch_syndrome_acc
  import bch_serial_syndrome_pkg::*;
#(
  parameter int M = 4,
  parameter int J = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         data_in,
  output logic [M-1:0] acc_next
);

  localparam gf_matrix_t MUL = power_matrix(1, J, M);

  logic [M-1:0] acc;
  logic [M-1:0] product;

  always_comb begin
    product = '0;
    for (int i = 0; i < M; i++) begin
      if (acc[i]) product = product ^ MUL[i][M-1:0];
    end
  end

  always_comb begin
    acc_next = acc;
    if (load) acc_next = {{(M-1){1'b0}}, data_in};
    else if (step) acc_next = product ^ {{(M-1){1'b0}}, data_in};
  end

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else       acc <= acc_next;
  end

endmodule

// File: rtl/bch_serial_syndrome.sv
// Bit-serial BCH syndrome generator: accumulates odd syndromes bit by bit and
// publishes all 2T syndromes through a one-entry valid/ready output register.
module bch_serial_syndrome
  import bch_serial_syndrome_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int N = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ce,
  input  logic             data_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*T*M-1:0] syndromes,
  output logic             out_err
);

  // Handshake: an input bit moves when ce && in_ready; the output word moves when
  // out_valid && out_ready, and a new word may load in that same cycle.

  localparam int CW = $clog2(N + 1);
  localparam gf_matrix_t SQ = power_matrix(2, 0, M);

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            accept, out_free;
  logic            load_acc, step_acc, xfer;
  logic [M-1:0]    odd_next [T];
  logic [2*T*M-1:0] synd_full;

  function automatic logic [M-1:0] gf_square(input logic [M-1:0] x);
    logic [M-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      if (x[i]) r = r ^ SQ[i][M-1:0];
    end
    return r;
  endfunction

  for (genvar t = 0; t < T; t++) begin : g_acc
    bch_syndrome_acc #(.M(M), .J(2 * t + 1)) u_acc (
      .clk      (clk),
      .reset    (reset),
      .load     (load_acc),
      .step     (step_acc),
      .data_in  (data_in),
      .acc_next (odd_next[t])
    );
  end

  // S_j with j = k*2^P (k odd) is S_k squared P times. In HOLD nothing steps,
  // so odd_next equals the held accumulators and one source serves both paths.
  for (genvar j = 1; j <= 2 * T; j++) begin : g_syn
    localparam int P = trailing_zeros(j);
    localparam int K = (j >> P) >> 1;
    logic [M-1:0] v [P+1];
    assign v[0] = odd_next[K];
    for (genvar p = 0; p < P; p++) begin : g_sq
      assign v[p+1] = gf_square(v[p]);
    end
    assign synd_full[(j-1)*M +: M] = v[P];
  end

  assign in_ready = (state != ST_HOLD);
  assign accept   = ce && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    load_acc   = 1'b0;
    step_acc   = 1'b0;
    xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && start) begin
          load_acc   = 1'b1;
          count_next = CW'(1);
          state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (start) begin
            load_acc   = 1'b1;
            count_next = CW'(1);
          end else begin
            step_acc   = 1'b1;
            count_next = count + 1'b1;
            if (count_next == CW'(N)) begin
              if (out_free) begin
                xfer       = 1'b1;
                state_next = ST_IDLE;
              end else begin
                state_next = ST_HOLD;
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          xfer       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      syndromes <= '0;
      out_err   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      syndromes <= synd_full;
      out_err   <= |synd_full;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/bch_serial_syndrome.md
# bch_serial_syndrome

Bit-serial syndrome generator for the binary BCH decoder. It accepts one received codeword bit per enabled cycle, highest-degree bit first, and accumulates the T odd syndromes S1, S3, …, S(2T-1) by Horner evaluation. It derives the even syndromes by squaring, then presents all 2T syndromes through a one-entry valid/ready output register. Upstream is the channel/bit-serial input; downstream is the error-locator (Berlekamp) stage.

## Interface
- `M`, default 4: field degree, GF(2^M).
- `T`, default 3: correctable errors; number of odd syndromes accumulated.
- `N`, default 15: codeword length in bits; legal range 2..2^M-1.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: marks the first bit of a codeword; only meaningful together with `ce`.
- `ce`, input, 1: `data_in` valid this cycle.
- `data_in`, input, 1: received bit, highest degree first.
- `in_ready`, output, 1: block accepts bits this cycle.
- `out_valid`, output, 1: `syndromes` and `out_err` hold a completed codeword.
- `out_ready`, input, 1: downstream consumes the output this cycle.
- `syndromes`, output, 2*T*M: S_j at `[(j-1)*M +: M]` for j = 1..2T, standard basis.
- `out_err`, output, 1: any syndrome nonzero.

## Operation
- A bit is accepted when `ce && in_ready`.
- FSM states and transitions:
  - IDLE: accepted bit with `start` loads accumulators S_j = {M-1'b0, data_in} for each odd j, sets count = 1, goes to ACC. Accepted bits without `start` are ignored.
  - ACC: for each accepted bit, S_j <= S_j·α^j + data_in (constant multiply), count++. An accepted bit with `start` restarts: the partial word is discarded and accumulators reload as in IDLE.
    - When count reaches N, the result transfers to the output register if it is free. The register is free when `!out_valid`, or when `out_valid && out_ready` in the same cycle. In that case go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: `in_ready = 0`. The accumulated result transfers to the output register once it is free, then go to IDLE.
- `in_ready = 1` in IDLE and ACC, 0 in HOLD.
- Output load:
  - Odd S_j are copied.
  - Even syndromes are computed as S_2k = (S_k)^2 through a squaring matrix.
  - `out_err` = OR of all syndromes.
  - Even syndromes and `out_err` are computed at load time and registered.
- `out_valid` sets on load and clears on `out_ready` when there is no simultaneous load. A simultaneous consume and load keeps it at 1 with the new data.
- Arithmetic: all GF(2^M) arithmetic uses the codebase primitive polynomial for `M`. The count is a plain binary counter of width clog2(N+1).

## Timing
- Reset values: state IDLE; `in_ready` = 1; `out_valid` = 0; `syndromes` = 0; `out_err` = 0; accumulators = 0; count = 0.
- Latency: `out_valid` rises the cycle after the N-th bit is accepted, provided the output register is free.
- Throughput: back-to-back codewords with zero gap while `out_ready` is held high.
- Output stability: `syndromes` and `out_err` are stable while `out_valid && !out_ready`.
- HOLD exit: `in_ready` returns to 1 the cycle after the HOLD→output transfer.
- `start` with `ce` low: ignored.
- Reset mid-codeword or mid-HOLD: partial data and any pending output are discarded.

## Structure
- Shared package (`bch.vh`) holds the field-constant helpers: `lpow`, `BCH_POLYNOMIAL`, `log2`. It gains one function: the constant α^j multiply matrix generator.
- Sub-module `bch_syndrome_acc #(M, J)`: one odd-syndrome accumulator register plus the constant multiply by α^J, instantiated T times via generate.
- Squaring reuses `parallel_standard_power #(M, 2)`.

## Test plan
(M=4, T=3, N=15, poly x^4+x+1, α = 4'b0010)
- **All-zero word:** 15 zero bits → `out_valid` next cycle; `syndromes` = 0, `out_err` = 0.
- **Error at degree 0:** 14 zeros then a 1 → every S_j = 4'b0001, `out_err` = 1.
- **Error at degree 1:** 13 zeros, 1, 0 → S1..S6 = 0010, 0100, 1000, 0011, 0110, 1100.
- **Backpressure:**
  - Hold `out_ready` = 0 and stream two words back-to-back (degree-0 error, then degree-1 error).
  - Required: `in_ready` drops the cycle after the second word's last bit.
  - Raise `out_ready`: both results delivered in order, `in_ready` back to 1.
- **Restart and ignore:**
  - Reassert `start` after 7 bits, then send the 15-bit degree-1 word → only the degree-1 syndromes appear.
  - Bits with `ce` but no `start` in IDLE produce no output.
- **Reset:** assert `reset` at bit 10 and while in HOLD → all outputs return to reset values; the next full word is processed correctly.
